// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: key debouncing, run/pause/countdown state machine,
// 10 ms prescaler and BCD time keeping. Drives the status pair (statue,
// countdown_done) and the BCD time digits consumed by the LED and display.
module stopwatch_ctrl #(
  parameter int         TICK_DIV = 1_000_000,
  parameter int         DEB_CYC  = 2_000_000,
  parameter logic [7:0] CD_MIN   = 8'h01,
  parameter logic [7:0] CD_SEC   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_run,
  input  logic       key_mode,
  input  logic       key_clr,
  output logic [1:0] statue,
  output logic       countdown_done,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [7:0] cs
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_CD    = 2'd2;

  localparam int K_RUN  = 0;
  localparam int K_MODE = 1;
  localparam int K_CLR  = 2;

  localparam int CW = $clog2(DEB_CYC + 1);
  localparam int PW = $clog2(TICK_DIV + 1);

  // Handshake note: there is no valid/ready pairing on this block; the
  // status pair is a level interface that sinks sample every cycle.

  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    filt_q, filt_d, press_q, press_d;
  logic [CW-1:0] deb_cnt_q [3];
  logic [CW-1:0] deb_cnt_d [3];
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    statue_q, statue_d;
  logic          done_q, done_d;
  logic [7:0]    mm_q, mm_d, ss_q, ss_d, cs_q, cs_d;

  logic          run_en, tick, key_evt;
  logic [8:0]    cs_up, ss_up, mm_up, cs_dn, ss_dn, mm_dn;

  // BCD increment with wrap at max; bit 8 is the carry out.
  function automatic logic [8:0] bcd_up(input logic [7:0] v, input logic [7:0] max);
    if (v == max)           return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9) return {1'b0, v[7:4] + 4'd1, 4'd0};
    else                    return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD decrement with wrap to max; bit 8 is the borrow out.
  function automatic logic [8:0] bcd_dn(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)          return {1'b1, max};
    else if (v[3:0] == 4'd0) return {1'b0, v[7:4] - 4'd1, 4'd9};
    else                     return {1'b0, v[7:4], v[3:0] - 4'd1};
  endfunction

  // Synchronize the raw keys, filter them and emit one pulse per press.
  always_comb begin
    sync1_d = {key_clr, key_mode, key_run};
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < 3; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (deb_cnt_q[i] == CW'(DEB_CYC - 1)) filt_d[i] = sync2_q[i];
        else                                  deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end
    end
    press_d = filt_d & ~filt_q;
  end

  // Prescaler, key actions and time update; key events override ticks.
  always_comb begin
    statue_d = statue_q;
    done_d   = done_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    cs_d     = cs_q;
    run_en   = (statue_q == ST_RUN) || ((statue_q == ST_CD) && !done_q);
    tick     = run_en && (pre_q == PW'(TICK_DIV - 1));
    key_evt  = |press_q;
    pre_d    = pre_q;
    if (key_evt || tick) pre_d = '0;
    else if (run_en)     pre_d = pre_q + PW'(1);

    cs_up = bcd_up(cs_q, 8'h99);
    ss_up = bcd_up(ss_q, 8'h59);
    mm_up = bcd_up(mm_q, 8'h99);
    cs_dn = bcd_dn(cs_q, 8'h99);
    ss_dn = bcd_dn(ss_q, 8'h59);
    mm_dn = bcd_dn(mm_q, 8'h99);

    if (press_q[K_CLR]) begin
      if (statue_q == ST_CD) begin
        {mm_d, ss_d, cs_d} = {CD_MIN, CD_SEC, 8'h00};
        done_d = 1'b0;
      end else begin
        statue_d = ST_PAUSE;
        {mm_d, ss_d, cs_d} = '0;
      end
    end else if (press_q[K_MODE]) begin
      done_d = 1'b0;
      if (statue_q == ST_CD) begin
        statue_d = ST_PAUSE;
        {mm_d, ss_d, cs_d} = '0;
      end else begin
        statue_d = ST_CD;
        {mm_d, ss_d, cs_d} = {CD_MIN, CD_SEC, 8'h00};
      end
    end else if (press_q[K_RUN]) begin
      case (statue_q)
        ST_RUN:   statue_d = ST_PAUSE;
        ST_PAUSE: statue_d = ST_RUN;
        ST_CD: if (done_q) begin
          {mm_d, ss_d, cs_d} = {CD_MIN, CD_SEC, 8'h00};
          done_d = 1'b0;
        end
        default:  statue_d = ST_PAUSE;
      endcase
    end else if ((statue_q == ST_CD) && !done_q && ({mm_q, ss_q, cs_q} == 24'h0)) begin
      // A zero preset has nothing to count; flag completion right away.
      done_d = 1'b1;
    end else if (tick) begin
      if (statue_q == ST_RUN) begin
        cs_d = cs_up[7:0];
        if (cs_up[8]) begin
          ss_d = ss_up[7:0];
          if (ss_up[8]) mm_d = mm_up[7:0];
        end
      end else begin
        cs_d = cs_dn[7:0];
        if (cs_dn[8]) begin
          ss_d = ss_dn[7:0];
          if (ss_dn[8]) mm_d = mm_dn[7:0];
        end
        done_d = ({mm_d, ss_d, cs_d} == 24'h0);
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      pre_q    <= '0;
      statue_q <= ST_PAUSE;
      done_q   <= 1'b0;
      mm_q     <= 8'h00;
      ss_q     <= 8'h00;
      cs_q     <= 8'h00;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      filt_q   <= filt_d;
      press_q  <= press_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      pre_q    <= pre_d;
      statue_q <= statue_d;
      done_q   <= done_d;
      mm_q     <= mm_d;
      ss_q     <= ss_d;
      cs_q     <= cs_d;
    end
  end

  assign statue         = statue_q;
  assign countdown_done = done_q;
  assign mm             = mm_q;
  assign ss             = ss_q;
  assign cs             = cs_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with small prescaler/debounce constants.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_run, key_mode, key_clr;
  logic [1:0] statue;
  logic       countdown_done;
  logic [7:0] mm, ss, cs;

  int vectors    = 0;
  int miscompares = 0;

  // Clock and DUT
  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV(4),
    .DEB_CYC (3),
    .CD_MIN  (8'h00),
    .CD_SEC  (8'h01)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .key_run       (key_run),
    .key_mode      (key_mode),
    .key_clr       (key_clr),
    .statue        (statue),
    .countdown_done(countdown_done),
    .mm            (mm),
    .ss            (ss),
    .cs            (cs)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_statue(input logic [1:0] v, input string tag);
    int n = 0;
    while (statue !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {30'd0, statue}, {30'd0, v});
  endtask

  task automatic wait_done(input logic v, input string tag);
    int n = 0;
    while (countdown_done !== v && n < 64) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, countdown_done}, {31'd0, v});
  endtask

  function automatic logic [31:0] t_now();
    return {8'h00, mm, ss, cs};
  endfunction

  initial begin
    int n;
    rst = 1'b1; key_run = 1'b0; key_mode = 1'b0; key_clr = 1'b0;
    cycles(3);
    rst = 1'b0;
    // Reset state
    check("rst_statue", {30'd0, statue}, 32'd1);
    check("rst_done",   {31'd0, countdown_done}, 32'd0);
    check("rst_time",   t_now(), 32'h000000);

    // Two-cycle glitch on key_run is filtered out
    key_run = 1'b1;
    cycles(2);
    key_run = 1'b0;
    cycles(12);
    check("glitch_statue", {30'd0, statue}, 32'd1);
    check("glitch_time",   t_now(), 32'h000000);

    // Held key_run: one press, PAUSE -> RUN, 400 cycles = 1.00 s
    key_run = 1'b1;
    wait_statue(2'd0, "run_enter");
    cycles(4);
    check("run_first_tick", t_now(), 32'h000001);
    cycles(6);
    key_run = 1'b0;
    cycles(390);
    check("run_1s", t_now(), 32'h000100);
    check("run_statue_held", {30'd0, statue}, 32'd0);

    // Seconds-to-minutes carry
    force dut.mm_q = 8'h00;
    force dut.ss_q = 8'h59;
    force dut.cs_q = 8'h99;
    #1;
    release dut.mm_q;
    release dut.ss_q;
    release dut.cs_q;
    n = 0;
    while (cs == 8'h99 && n < 16) begin @(negedge clk); n++; end
    check("carry_min", t_now(), 32'h010000);

    // Full-scale wrap stays in RUN
    force dut.mm_q = 8'h99;
    force dut.ss_q = 8'h59;
    force dut.cs_q = 8'h99;
    #1;
    release dut.mm_q;
    release dut.ss_q;
    release dut.cs_q;
    n = 0;
    while (cs == 8'h99 && n < 16) begin @(negedge clk); n++; end
    check("wrap_time",   t_now(), 32'h000000);
    check("wrap_statue", {30'd0, statue}, 32'd0);

    // Pause
    cycles(2);
    key_run = 1'b1;
    wait_statue(2'd1, "pause_enter");
    cycles(8);
    key_run = 1'b0;
    cycles(8);

    // Countdown from preset 00:01.00
    key_mode = 1'b1;
    wait_statue(2'd2, "cd_enter");
    check("cd_preset", t_now(), 32'h000100);
    check("cd_done0",  {31'd0, countdown_done}, 32'd0);
    cycles(4);
    check("cd_borrow", t_now(), 32'h000099);
    key_mode = 1'b0;
    cycles(196);
    check("cd_half", t_now(), 32'h000050);
    cycles(199);
    check("cd_last_time", t_now(), 32'h000001);
    check("cd_last_done", {31'd0, countdown_done}, 32'd0);
    cycles(1);
    check("cd_zero_time", t_now(), 32'h000000);
    check("cd_zero_done", {31'd0, countdown_done}, 32'd1);
    cycles(40);
    check("cd_hold_time",   t_now(), 32'h000000);
    check("cd_hold_done",   {31'd0, countdown_done}, 32'd1);
    check("cd_hold_statue", {30'd0, statue}, 32'd2);

    // Restart with run while done
    key_run = 1'b1;
    wait_done(1'b0, "restart_done");
    check("restart_time",   t_now(), 32'h000100);
    check("restart_statue", {30'd0, statue}, 32'd2);
    cycles(8);
    key_run = 1'b0;
    cycles(8);

    // Leave countdown with mode
    key_mode = 1'b1;
    wait_statue(2'd1, "cd_exit");
    check("cd_exit_time", t_now(), 32'h000000);
    check("cd_exit_done", {31'd0, countdown_done}, 32'd0);
    cycles(8);
    key_mode = 1'b0;
    cycles(8);

    // Run to 00:00.37, then clr and run together: clr wins
    key_run = 1'b1;
    wait_statue(2'd0, "run2_enter");
    cycles(8);
    key_run = 1'b0;
    cycles(140);
    check("run2_37", t_now(), 32'h000037);
    key_run = 1'b1;
    key_clr = 1'b1;
    wait_statue(2'd1, "clr_win_statue");
    check("clr_win_time", t_now(), 32'h000000);
    cycles(10);
    check("clr_paused_time", t_now(), 32'h000000);
    key_run = 1'b0;
    key_clr = 1'b0;
    cycles(8);

    // Reset during an active countdown
    key_mode = 1'b1;
    wait_statue(2'd2, "cd2_enter");
    cycles(20);
    key_mode = 1'b0;
    rst = 1'b1;
    cycles(1);
    check("rst_cd_statue", {30'd0, statue}, 32'd1);
    check("rst_cd_done",   {31'd0, countdown_done}, 32'd0);
    check("rst_cd_time",   t_now(), 32'h000000);
    rst = 1'b0;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
